// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: lock-qualified, staged system/VDP reset release,
// free-running /4 and /24 clock enables, and a saturating count of
// filtered PLL lock losses. Single clock domain (PLL clkout).
module pll_reset_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_GAP_CYCLES   = 16,
    parameter int unsigned LOSS_FILTER_CYCLES = 4,
    parameter int unsigned CNT_W              = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_lock,
    output logic       sys_reset_n,
    output logic       vdp_reset_n,
    output logic       enable_21m,
    output logic       enable_3m58,
    output logic [7:0] relock_count
);

    localparam int unsigned DIV4_W  = 2;
    localparam int unsigned DIV24_W = 5;
    localparam int unsigned LOSS_W  = $clog2(LOSS_FILTER_CYCLES + 1);

    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST    = CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [LOSS_W-1:0]  LOSS_LAST   = LOSS_W'(LOSS_FILTER_CYCLES - 1);
    localparam logic [DIV4_W-1:0]  DIV4_PRE    = DIV4_W'(2);
    localparam logic [DIV24_W-1:0] DIV24_PRE   = DIV24_W'(22);
    localparam logic [DIV24_W-1:0] DIV24_LAST  = DIV24_W'(23);

    typedef enum logic [1:0] {
        WAIT_LOCK   = 2'd0,
        STABLE      = 2'd1,
        RELEASE_SYS = 2'd2,
        RUN         = 2'd3
    } state_t;

    state_t               state;
    logic                 lock_meta;
    logic                 lock_s;
    logic [CNT_W-1:0]     cnt;
    logic [LOSS_W-1:0]    loss_cnt;
    logic [DIV4_W-1:0]    div4;
    logic [DIV24_W-1:0]   div24;

    logic                 loss_trip_c;
    logic                 sys_next_c;
    logic                 vdp_next_c;

    // Two-flop synchronizer for the asynchronous PLL lock flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Next values of the reset outputs; a loss-filter trip beats any release.
    always_comb begin
        loss_trip_c = 1'b0;
        sys_next_c  = 1'b0;
        vdp_next_c  = 1'b0;
        if ((state == RELEASE_SYS || state == RUN) && !lock_s && (loss_cnt == LOSS_LAST)) begin
            loss_trip_c = 1'b1;
        end
        case (state)
            WAIT_LOCK: begin
                sys_next_c = 1'b0;
                vdp_next_c = 1'b0;
            end
            STABLE: begin
                sys_next_c = lock_s && (cnt == STABLE_LAST);
                vdp_next_c = 1'b0;
            end
            RELEASE_SYS: begin
                sys_next_c = !loss_trip_c;
                vdp_next_c = !loss_trip_c && (cnt == GAP_LAST);
            end
            RUN: begin
                sys_next_c = !loss_trip_c;
                vdp_next_c = !loss_trip_c;
            end
            default: begin
                sys_next_c = 1'b0;
                vdp_next_c = 1'b0;
            end
        endcase
    end

    // Sequencer FSM: lock qualification, staged release, loss filtering.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            loss_cnt     <= '0;
            relock_count <= 8'd0;
            sys_reset_n  <= 1'b0;
            vdp_reset_n  <= 1'b0;
        end else begin
            sys_reset_n <= sys_next_c;
            vdp_reset_n <= vdp_next_c;
            case (state)
                WAIT_LOCK: begin
                    cnt      <= '0;
                    loss_cnt <= '0;
                    if (lock_s) begin
                        state <= STABLE;
                    end
                end
                STABLE: begin
                    loss_cnt <= '0;
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state <= RELEASE_SYS;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RELEASE_SYS: begin
                    if (loss_trip_c) begin
                        state    <= WAIT_LOCK;
                        cnt      <= '0;
                        loss_cnt <= '0;
                        if (relock_count != 8'hFF) begin
                            relock_count <= relock_count + 8'd1;
                        end
                    end else begin
                        loss_cnt <= lock_s ? '0 : loss_cnt + LOSS_W'(1);
                        if (cnt == GAP_LAST) begin
                            state <= RUN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (loss_trip_c) begin
                        state    <= WAIT_LOCK;
                        cnt      <= '0;
                        loss_cnt <= '0;
                        if (relock_count != 8'hFF) begin
                            relock_count <= relock_count + 8'd1;
                        end
                    end else begin
                        loss_cnt <= lock_s ? '0 : loss_cnt + LOSS_W'(1);
                    end
                end
                default: begin
                    state    <= WAIT_LOCK;
                    cnt      <= '0;
                    loss_cnt <= '0;
                end
            endcase
        end
    end

    // Clock-enable dividers; held at phase 0 whenever sys_reset_n is (or goes) low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div4        <= '0;
            div24       <= '0;
            enable_21m  <= 1'b0;
            enable_3m58 <= 1'b0;
        end else if (sys_reset_n && sys_next_c) begin
            div4        <= div4 + DIV4_W'(1);
            div24       <= (div24 == DIV24_LAST) ? '0 : div24 + DIV24_W'(1);
            enable_21m  <= (div4 == DIV4_PRE);
            enable_3m58 <= (div24 == DIV24_PRE);
        end else begin
            div4        <= '0;
            div24       <= '0;
            enable_21m  <= 1'b0;
            enable_3m58 <= 1'b0;
        end
    end

endmodule
